// File: rtl/ccw_rotation_sequencer_if.sv
// Placement-check handshake between the CCW rotation
// sequencer and the board collision checker.
interface ccw_rotation_sequencer_if #(
  parameter int X_W = 5,
  parameter int Y_W = 6
);
  logic                  req;
  logic signed [X_W-1:0] x;
  logic signed [Y_W-1:0] y;
  logic [1:0]            rotation;
  logic                  ack;
  logic                  collide;

  modport master (
    output req, x, y, rotation,
    input  ack, collide
  );

  modport slave (
    input  req, x, y, rotation,
    output ack, collide
  );
endinterface

// File: rtl/ccw_rotation_sequencer.sv
// CCW rotation engine: walks the five SRS wall-kick
// candidates through the collision checker, one per ack.
package ccw_rotation_sequencer_pkg;
  typedef logic [2:0] tetromino_idx_t;
  localparam tetromino_idx_t TETROMINO_I_IDX = 3'd0;
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;
endpackage

module ccw_rotation_sequencer
  import ccw_rotation_sequencer_pkg::*;
#(
  parameter int X_W = 5,
  parameter int Y_W = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  tetromino_idx_t        idx,
  input  logic [1:0]            rotation,
  input  logic signed [X_W-1:0] pos_x,
  input  logic signed [Y_W-1:0] pos_y,
  ccw_rotation_sequencer_if.master chk,
  output logic                  busy,
  output logic                  done,
  output logic                  success,
  output logic signed [X_W-1:0] res_x,
  output logic signed [Y_W-1:0] res_y,
  output logic [1:0]            res_rotation
);

  localparam logic [2:0] Z  = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] M2 = 3'b110;

  state_t state, nstate;

  logic                  lat_i;
  logic [1:0]            lat_rot;
  logic signed [X_W-1:0] lat_x;
  logic signed [Y_W-1:0] lat_y;
  logic [2:0]            step;

  logic [5:0]            k;
  logic signed [X_W-1:0] cand_x;
  logic signed [Y_W-1:0] cand_y;
  logic [1:0]            cand_rot;
  logic                  last;

  // Row holds {kx,ky} for steps 1..4, step 1 in the top bits
  function automatic logic [5:0] kick(
    input logic       is_i,
    input logic [1:0] rot,
    input logic [2:0] s
  );
    logic [23:0] row;
    logic [5:0]  r;
    row = '0;
    r   = '0;
    unique case ({is_i, rot})
      3'b000: row = {P1, Z, P1, P1, Z, M2, P1, M2};
      3'b001: row = {P1, Z, P1, M1, Z, P2, P1, P2};
      3'b010: row = {M1, Z, M1, P1, Z, M2, M1, M2};
      3'b011: row = {M1, Z, M1, M1, Z, P2, M1, P2};
      3'b100: row = {M1, Z, P2, Z, M1, P2, P2, M1};
      3'b101: row = {M2, Z, P1, Z, M2, M1, P1, P2};
      3'b110: row = {P1, Z, M2, Z, P1, M2, M2, P1};
      3'b111: row = {P2, Z, M1, Z, P2, P1, M1, M2};
      default: row = '0;
    endcase
    unique case (s)
      3'd1:    r = row[23:18];
      3'd2:    r = row[17:12];
      3'd3:    r = row[11:6];
      3'd4:    r = row[5:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign k        = kick(lat_i, lat_rot, step);
  assign cand_x   = lat_x + {{(X_W-3){k[5]}}, k[5:3]};
  assign cand_y   = lat_y + {{(Y_W-3){k[2]}}, k[2:0]};
  assign cand_rot = lat_rot - 2'd1;
  assign last     = (step == 3'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start) nstate = REQ;
      REQ: begin
        if (chk.ack && (!chk.collide || last))
          nstate = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    chk.req      = 1'b0;
    chk.x        = '0;
    chk.y        = '0;
    chk.rotation = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      REQ: begin
        chk.req      = 1'b1;
        chk.x        = cand_x;
        chk.y        = cand_y;
        chk.rotation = cand_rot;
        busy         = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_i        <= 1'b0;
      lat_rot      <= '0;
      lat_x        <= '0;
      lat_y        <= '0;
      step         <= '0;
      success      <= 1'b0;
      res_x        <= '0;
      res_y        <= '0;
      res_rotation <= '0;
    end else if (state == IDLE && start) begin
      lat_i   <= (idx == TETROMINO_I_IDX);
      lat_rot <= rotation;
      lat_x   <= pos_x;
      lat_y   <= pos_y;
      step    <= '0;
      success <= 1'b0;
    end else if (state == REQ && chk.ack) begin
      if (!chk.collide) begin
        res_x        <= cand_x;
        res_y        <= cand_y;
        res_rotation <= cand_rot;
        success      <= 1'b1;
      end else if (!last) begin
        step <= step + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ccw_rotation_sequencer.sv
// Randomized bench for ccw_rotation_sequencer against a
// table-driven SRS kick model with a scripted checker.
module tb_ccw_rotation_sequencer;
  import ccw_rotation_sequencer_pkg::*;

  localparam int X_W = 5;
  localparam int Y_W = 6;
  localparam tetromino_idx_t J = 3'd5;

  // [is_i][rotation][step] kick offsets
  localparam int KX [2][4][5] = '{
    '{'{0, 1, 1, 0, 1}, '{0, 1, 1, 0, 1},
      '{0, -1, -1, 0, -1}, '{0, -1, -1, 0, -1}},
    '{'{0, -1, 2, -1, 2}, '{0, -2, 1, -2, 1},
      '{0, 1, -2, 1, -2}, '{0, 2, -1, 2, -1}}
  };
  localparam int KY [2][4][5] = '{
    '{'{0, 0, 1, -2, -2}, '{0, 0, -1, 2, 2},
      '{0, 0, 1, -2, -2}, '{0, 0, -1, 2, 2}},
    '{'{0, 0, 0, 2, -1}, '{0, 0, 0, -1, 2},
      '{0, 0, 0, -2, 1}, '{0, 0, 0, 1, -2}}
  };

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  tetromino_idx_t idx = '0;
  logic [1:0] rotation = '0;
  logic signed [X_W-1:0] pos_x = '0;
  logic signed [Y_W-1:0] pos_y = '0;
  logic busy, done, success;
  logic signed [X_W-1:0] res_x;
  logic signed [Y_W-1:0] res_y;
  logic [1:0] res_rotation;

  ccw_rotation_sequencer_if #(.X_W(X_W), .Y_W(Y_W)) chk_if ();

  ccw_rotation_sequencer #(.X_W(X_W), .Y_W(Y_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .idx          (idx),
    .rotation     (rotation),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .chk          (chk_if.master),
    .busy         (busy),
    .done         (done),
    .success      (success),
    .res_x        (res_x),
    .res_y        (res_y),
    .res_rotation (res_rotation)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [X_W-1:0] m_res_x = '0;
  logic signed [Y_W-1:0] m_res_y = '0;
  logic [1:0]            m_res_rot = '0;
  logic                  m_succ = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_res();
    check("success", success, m_succ);
    check("res_x", res_x, m_res_x);
    check("res_y", res_y, m_res_y);
    check("res_rot", res_rotation, m_res_rot);
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE
  task automatic run_txn(input tetromino_idx_t id,
                         input logic [1:0] rot,
                         input int px, input int py,
                         input int ncoll,
                         input int stall_step,
                         input int stall_len,
                         input bit rnd);
    logic signed [X_W-1:0] ex;
    logic signed [Y_W-1:0] ey;
    logic [1:0] er;
    int ii, w;
    ii = (id == TETROMINO_I_IDX) ? 1 : 0;
    er = rot - 2'd1;
    ex = '0;
    ey = '0;
    idx = id;
    rotation = rot;
    pos_x = X_W'(px);
    pos_y = Y_W'(py);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 3'($urandom);
    rotation = 2'($urandom);
    pos_x = X_W'($urandom);
    pos_y = Y_W'($urandom);
    for (int s = 0; s < 5; s++) begin
      ex = X_W'(px + KX[ii][rot][s]);
      ey = Y_W'(py + KY[ii][rot][s]);
      if (s == stall_step) w = stall_len;
      else w = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int c = 0; c <= w; c++) begin
        check("chk_req", chk_if.req, 1'b1);
        check("chk_x", chk_if.x, ex);
        check("chk_y", chk_if.y, ey);
        check("chk_rot", chk_if.rotation, er);
        check("busy", busy, 1'b1);
        check("done_early", done, 1'b0);
        chk_if.ack = (c == w);
        chk_if.collide = (c == w) ? (s < ncoll)
                                  : 1'($urandom);
        start = rnd ? 1'($urandom) : 1'b0;
        @(negedge clk);
      end
      if (s >= ncoll) break;
    end
    if (ncoll < 5) begin
      m_res_x = ex;
      m_res_y = ey;
      m_res_rot = er;
      m_succ = 1'b1;
    end else begin
      m_succ = 1'b0;
    end
    chk_if.ack = 1'b0;
    start = rnd ? 1'($urandom) : 1'b0;
    check("done", done, 1'b1);
    check("req_in_done", chk_if.req, 1'b0);
    check_res();
    @(negedge clk);
    start = 1'b0;
    check("done_once", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("req_after", chk_if.req, 1'b0);
    check_res();
  endtask

  task automatic stray_idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk_if.ack = 1'($urandom);
      chk_if.collide = 1'($urandom);
      @(negedge clk);
      check("idle_req", chk_if.req, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end
    chk_if.ack = 1'b0;
    chk_if.collide = 1'b0;
  endtask

  initial begin
    chk_if.ack = 1'b0;
    chk_if.collide = 1'b0;
    #3;
    check("rst_req", chk_if.req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_x", chk_if.x, 0);
    check("rst_y", chk_if.y, 0);
    check("rst_rot", chk_if.rotation, 0);
    check_res();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(J, 2'd0, 4, 10, 0, -1, 0, 1'b0);
    run_txn(J, 2'd1, 4, 10, 3, -1, 0, 1'b0);
    run_txn(TETROMINO_I_IDX, 2'd2, 3, 5, 5, -1, 0, 1'b0);
    run_txn(3'd6, 2'd3, -3, 7, 2, 1, 3, 1'b0);
    stray_idle(4);

    // Abort at step 2 with an asynchronous reset
    idx = J;
    rotation = 2'd0;
    pos_x = 5'sd4;
    pos_y = 6'sd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk_if.ack = 1'b1;
      chk_if.collide = 1'b1;
      @(negedge clk);
    end
    chk_if.ack = 1'b0;
    check("step2_x", chk_if.x, 5);
    check("step2_y", chk_if.y, 11);
    #2 reset_n = 1'b0;
    #1;
    check("arst_req", chk_if.req, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    m_res_x = '0;
    m_res_y = '0;
    m_res_rot = '0;
    m_succ = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_res();
    stray_idle(3);
    run_txn(J, 2'd2, 7, 20, 0, -1, 0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      run_txn(3'($urandom_range(0, 6)), 2'($urandom),
              int'($urandom_range(0, 31)),
              int'($urandom_range(0, 63)),
              int'($urandom_range(0, 5)), -1, 0, 1'b1);
      if ((t % 8) == 0) stray_idle(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ccw_rotation_sequencer.md
Name: ccw_rotation_sequencer

Overview:
Sequential counterclockwise-rotation engine for the active tetromino. It applies the five SRS wall-kick tests for CCW rotation (0>>3, 3>>2, 2>>1, 1>>0) one at a time against the board collision checker. It reports the first non-colliding placement or a failure. It sits between the input/game-control FSM and the board collision checker; it is the CCW counterpart of the clockwise kick path.

Parameters:
X_W, 5, signed width of piece x coordinate
Y_W, 6, signed width of piece y coordinate

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request CCW rotation; sampled only in IDLE
idx  in  tetromino_idx_t  piece type; only `TETROMINO_I_IDX is distinguished
rotation  in  2  current rotation state 0..3
pos_x  in  X_W signed  current piece x
pos_y  in  Y_W signed  current piece y
chk_req  out  1  candidate placement valid, held until acknowledged
chk_x  out  X_W signed  candidate x
chk_y  out  Y_W signed  candidate y
chk_rotation  out  2  candidate rotation, always (rotation-1) mod 4
chk_ack  in  1  checker has evaluated the candidate; may rise in the same cycle as chk_req
chk_collide  in  1  candidate collides; valid only when chk_ack=1
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
success  out  1  result valid with done; held until next start
res_x, res_y, res_rotation  out  X_W/Y_W/2  accepted placement; unchanged on failure

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: state=IDLE; chk_req, busy, done, success = 0; res_*, chk_* = 0.
- States:
  - IDLE: on start, latch idx, rotation, pos_x, pos_y; set step=0; go to REQ.
  - REQ: chk_req=1 with the candidate for the current step. On chk_ack:
    - chk_collide=0 -> load res_* with the candidate, success=1, go to DONE.
    - chk_collide=1 and step<4 -> step+1, stay in REQ (chk_req stays high; new candidate next cycle).
    - chk_collide=1 and step=4 -> success=0, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Candidate: chk_x = pos_x + sext(kx), chk_y = pos_y + sext(ky). kx and ky are 3-bit signed. Sums wrap modulo 2^W with no saturation; the checker rejects out-of-board positions.
- Kick table, (kx,ky) for steps 1..4; step 0 = (0,0) for all pieces:
  - non-I r0: (1,0)(1,1)(0,-2)(1,-2)
  - non-I r1: (1,0)(1,-1)(0,2)(1,2)
  - non-I r2: (-1,0)(-1,1)(0,-2)(-1,-2)
  - non-I r3: (-1,0)(-1,-1)(0,2)(-1,2)
  - I r0: (-1,0)(2,0)(-1,2)(2,-1)
  - I r1: (-2,0)(1,0)(-2,-1)(1,2)
  - I r2: (1,0)(-2,0)(1,-2)(-2,1)
  - I r3: (2,0)(-1,0)(2,1)(-1,-2)
  - The O piece uses the non-I table; step 0 always succeeds given a legal start position.
- Latency: start at cycle 0 -> chk_req at cycle 1. With ack in the same cycle as req, each step costs 1 cycle; done rises 1 cycle after the deciding ack. Best case: done at cycle 2. Worst case (5 tests, zero-wait ack): done at cycle 6.
- chk_x, chk_y, chk_rotation are stable while chk_req=1 and chk_ack=0.
- start during busy/DONE is ignored; no queuing. Inputs changing after start have no effect.
- chk_ack while chk_req=0 is ignored.
- reset_n low mid-operation: immediately return to IDLE; chk_req drops asynchronously; no done pulse.

Test Plan:
- Non-I (J), rotation=0, pos=(4,10), ack every cycle, collide=0 -> chk=(4,10,rot 3); done at cycle 2; success=1; res=(4,10,3).
- J, rotation=1, pos=(4,10), collide=1 for steps 0-2, 0 at step 3 -> candidates (4,10)(5,10)(5,9)(4,12); res=(4,12,0); done at cycle 5.
- I, rotation=2, pos=(3,5), collide all 5 -> candidates (3,5)(4,5)(1,5)(4,3)(1,6); success=0; res_* unchanged; exactly one done pulse.
- Delayed ack: hold chk_ack=0 for 3 cycles at step 1 -> chk_req and chk_x/chk_y stable across the stall; the step advances only after ack.
- start asserted again while busy, and a stray chk_ack in IDLE -> no effect; busy and the step count are unaffected.
- reset_n low during REQ at step 2 -> chk_req=0, busy=0, done never pulses; a subsequent start begins at step 0.
